// File: rtl/sc_muxn1_rr_reg.sv
// Registered N:1 channel multiplexer with direct-select or round-robin arbitration.
// The selected word sits in a one-deep output register behind a valid/ready handshake.
module sc_muxn1_rr_reg #(
   parameter int NUMBER_DATAWIDTH = 8,
   parameter int NUMBER_CHANNELS  = 4,
   parameter int SELECT_WIDTH     = 2
) (
   input  logic                                         SC_MUXN1_CLOCK_50,
   input  logic                                         SC_MUXN1_RESET_InLow,
   input  logic                                         SC_MUXN1_mode_In,
   input  logic [SELECT_WIDTH-1:0]                      SC_MUXN1_select_InBUS,
   input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0]  SC_MUXN1_data_InBUS,
   input  logic [NUMBER_CHANNELS-1:0]                   SC_MUXN1_valid_InBUS,
   output logic [NUMBER_CHANNELS-1:0]                   SC_MUXN1_ready_OutBUS,
   output logic [NUMBER_DATAWIDTH-1:0]                  SC_MUXN1_z_Out,
   output logic                                         SC_MUXN1_valid_Out,
   input  logic                                         SC_MUXN1_ready_In,
   output logic [SELECT_WIDTH-1:0]                      SC_MUXN1_chan_Out
);

   localparam logic [SELECT_WIDTH-1:0]    PTR_INIT = SELECT_WIDTH'(NUMBER_CHANNELS - 1);
   localparam logic [NUMBER_CHANNELS-1:0] ONE_N    = NUMBER_CHANNELS'(1);

   logic [NUMBER_DATAWIDTH-1:0] r_z;
   logic                        r_valid;
   logic [SELECT_WIDTH-1:0]     r_chan;
   logic [SELECT_WIDTH-1:0]     r_ptr;

   logic                        w_free;
   logic [NUMBER_CHANNELS-1:0]  w_dir_oh;
   logic [NUMBER_CHANNELS-1:0]  w_hi_mask;
   logic [NUMBER_CHANNELS-1:0]  w_rr_req_hi;
   logic [NUMBER_CHANNELS-1:0]  w_rr_pool;
   logic [NUMBER_CHANNELS-1:0]  w_rr_oh;
   logic [NUMBER_CHANNELS-1:0]  w_grant_oh;
   logic [NUMBER_CHANNELS-1:0]  w_ready;
   logic                        w_transfer;
   logic [SELECT_WIDTH-1:0]     w_grant_idx;
   logic [NUMBER_DATAWIDTH-1:0] w_grant_data;

   // Transposed views: per index bit, which channels carry a 1; per data bit, the channel column.
   logic [NUMBER_CHANNELS-1:0]  w_idx_mask [SELECT_WIDTH];
   logic [NUMBER_CHANNELS-1:0]  w_data_col [NUMBER_DATAWIDTH];

   assign w_free = !r_valid || SC_MUXN1_ready_In;

   genvar gi, gb, gd;
   generate
      for (gi = 0; gi < NUMBER_CHANNELS; gi = gi + 1) begin : g_chan
         // An out-of-range select matches no channel, so it can never produce a grant.
         assign w_dir_oh[gi]  = SC_MUXN1_valid_InBUS[gi] &&
                                (SC_MUXN1_select_InBUS == SELECT_WIDTH'(gi));
         assign w_hi_mask[gi] = (SELECT_WIDTH'(gi) > r_ptr);

         for (gb = 0; gb < SELECT_WIDTH; gb = gb + 1) begin : g_idx_bit
            assign w_idx_mask[gb][gi] = (((gi >> gb) & 1) != 0);
         end

         for (gd = 0; gd < NUMBER_DATAWIDTH; gd = gd + 1) begin : g_data_bit
            assign w_data_col[gd][gi] = SC_MUXN1_data_InBUS[gi*NUMBER_DATAWIDTH + gd];
         end
      end

      for (gb = 0; gb < SELECT_WIDTH; gb = gb + 1) begin : g_enc
         assign w_grant_idx[gb] = |(w_grant_oh & w_idx_mask[gb]);
      end

      for (gd = 0; gd < NUMBER_DATAWIDTH; gd = gd + 1) begin : g_mux
         assign w_grant_data[gd] = |(w_grant_oh & w_data_col[gd]);
      end
   endgenerate

   // Round-robin: prefer valid channels above the pointer, else wrap to the lowest valid one.
   assign w_rr_req_hi = SC_MUXN1_valid_InBUS & w_hi_mask;
   assign w_rr_pool   = (|w_rr_req_hi) ? w_rr_req_hi : SC_MUXN1_valid_InBUS;
   assign w_rr_oh     = w_rr_pool & (~w_rr_pool + ONE_N);

   assign w_grant_oh  = SC_MUXN1_mode_In ? w_rr_oh : w_dir_oh;

   // No accept strobe while reset is held: the word would be dropped by the reset edge.
   assign w_ready     = (SC_MUXN1_RESET_InLow && w_free) ? w_grant_oh : '0;
   assign w_transfer  = |w_ready;

   always_ff @(posedge SC_MUXN1_CLOCK_50) begin
      if (!SC_MUXN1_RESET_InLow) begin
         r_z     <= '0;
         r_valid <= 1'b0;
         r_chan  <= '0;
         r_ptr   <= PTR_INIT;
      end else if (w_transfer) begin
         r_z     <= w_grant_data;
         r_chan  <= w_grant_idx;
         r_valid <= 1'b1;
         if (SC_MUXN1_mode_In) begin
            r_ptr <= w_grant_idx;
         end
      end else if (SC_MUXN1_ready_In) begin
         r_valid <= 1'b0;
      end
   end

   assign SC_MUXN1_ready_OutBUS = w_ready;
   assign SC_MUXN1_z_Out        = r_z;
   assign SC_MUXN1_valid_Out    = r_valid;
   assign SC_MUXN1_chan_Out     = r_chan;

endmodule
